// File: rtl/wb_load_commit_unit.sv
// wb_load_commit_unit
// -------------------
// Registered write-back stage for the pipelined MIPS core. It picks the
// W-stage result from one of four sources: the ALU output, aligned and
// extended load data, PC+4, or zero. It registers that result and commits it
// to the register file one cycle later.
//
// A load whose data memory response has not arrived stalls the pipeline. The
// load is then tracked in a small IDLE/WAIT FSM until the response arrives or
// a watchdog abandons it.
//
// Optional feature macro: WB_ALIGN_CHECK_EN
//   defined   : misaligned loads still wait for their response (or timeout),
//               then commit with o_RegWriteW=0 and pulse o_AlignErrW.
//   undefined : o_AlignErrW is tied low; misaligned lanes are extracted by
//               plain right shift with zero fill.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_ValidW          instruction present in W
//   i_ALUOutW         ALU result / load effective address
//   i_PCPlus4W        link value
//   i_MemtoRegW       00 ALU, 01 memory, 10 PC+4, 11 zero
//   i_MemDataSelW     load format (full/half/byte/word, signed/unsigned)
//   i_RegWriteW       register write enable
//   i_WriteRegW       destination register
//   i_MemRspValid     load data valid this cycle
//   i_MemRspData      full aligned memory word
//   o_StallW          combinational stall of W and earlier stages
//   o_WbValidW        commit strobe
//   o_RegWriteW       register-file write enable
//   o_WriteRegW       destination register
//   o_ResultW         write data
//   o_MemTimeoutW     one-cycle pulse when a load is abandoned
//   o_AlignErrW       one-cycle pulse on a misaligned load commit

module wb_load_commit_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ValidW,
  input  logic [DATA_WIDTH-1:0]     i_ALUOutW,
  input  logic [ADDRESS_WIDTH-1:0]  i_PCPlus4W,
  input  logic [1:0]                i_MemtoRegW,
  input  logic [2:0]                i_MemDataSelW,
  input  logic                      i_RegWriteW,
  input  logic [REG_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                      i_MemRspValid,
  input  logic [DATA_WIDTH-1:0]     i_MemRspData,
  output logic                      o_StallW,
  output logic                      o_WbValidW,
  output logic                      o_RegWriteW,
  output logic [REG_ADDR_WIDTH-1:0] o_WriteRegW,
  output logic [DATA_WIDTH-1:0]     o_ResultW,
  output logic                      o_MemTimeoutW,
  output logic                      o_AlignErrW
);

  localparam int OFFW = $clog2(DATA_WIDTH / 8);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [OFFW-1:0]           off_cap_q, off_cap_d;
  logic [2:0]                sel_cap_q, sel_cap_d;
  logic                      rw_cap_q, rw_cap_d;
  logic [REG_ADDR_WIDTH-1:0] wreg_cap_q, wreg_cap_d;

  logic                      wb_valid_q, wb_valid_d;
  logic                      reg_write_q, reg_write_d;
  logic [REG_ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic                      timeout_q, timeout_d;
  logic                      align_err_q, align_err_d;

  logic                      stall;
  logic                      is_load;
  logic [OFFW-1:0]           off_live;
  logic [DATA_WIDTH-1:0]     pc_ext;
  logic                      mis_live;
  logic                      mis_cap;

  // Byte offset of the load inside the memory word.
  assign off_live = i_ALUOutW[OFFW-1:0];
  assign is_load  = i_ValidW & (i_MemtoRegW == 2'b01);

  // The link value is either zero-extended or truncated to the datapath.
  generate
    if (ADDRESS_WIDTH >= DATA_WIDTH) begin : g_pc_trunc
      assign pc_ext = i_PCPlus4W[DATA_WIDTH-1:0];
    end else begin : g_pc_zext
      assign pc_ext = {{(DATA_WIDTH - ADDRESS_WIDTH){1'b0}}, i_PCPlus4W};
    end
  endgenerate

  // The memory word is always shifted right by the byte offset first. The
  // selected lane is then taken from the low bits and extended. Because the
  // shift fills with zeros, misaligned lanes pick up zeros from above the
  // word.
  function automatic logic [DATA_WIDTH-1:0] extract_load(
    input logic [DATA_WIDTH-1:0] data,
    input logic [OFFW-1:0]       off,
    input logic [2:0]            sel
  );
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext;
    shifted = data >> {off, 3'b000};
    ext     = '0;
    case (sel)
      3'b000: ext = shifted;
      3'b001: ext = DATA_WIDTH'($signed(shifted[15:0]));
      3'b010: ext = DATA_WIDTH'(shifted[15:0]);
      3'b011: ext = DATA_WIDTH'($signed(shifted[7:0]));
      3'b100: ext = DATA_WIDTH'(shifted[7:0]);
      3'b101: ext = (DATA_WIDTH == 64) ? DATA_WIDTH'($signed(shifted[31:0])) : '0;
      3'b110: ext = (DATA_WIDTH == 64) ? DATA_WIDTH'(shifted[31:0]) : '0;
      default: ext = '0;
    endcase
    return ext;
  endfunction

`ifdef WB_ALIGN_CHECK_EN
  // A half access needs an even offset. A word access (64-bit only) needs a
  // 4-byte-aligned offset. A full-width access needs offset zero.
  function automatic logic is_misaligned(
    input logic [OFFW-1:0] off,
    input logic [2:0]      sel
  );
    logic mis;
    mis = 1'b0;
    case (sel)
      3'b000:         mis = (off != '0);
      3'b001, 3'b010: mis = off[0];
      3'b101, 3'b110: mis = (DATA_WIDTH == 64) && (off[1:0] != 2'b00);
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

  assign mis_live = is_misaligned(off_live, i_MemDataSelW);
  assign mis_cap  = is_misaligned(off_cap_q, sel_cap_q);
`else
  assign mis_live = 1'b0;
  assign mis_cap  = 1'b0;
`endif

  // Next-state and commit logic. Output flops default to "no commit": the
  // strobes are cleared, while data and destination hold their last values.
  // A timeout counts as a commit: it carries zero data, does not write the
  // register file, and pulses the timeout flag. A response that arrives in
  // the last watchdog cycle beats the timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_cap_d   = off_cap_q;
    sel_cap_d   = sel_cap_q;
    rw_cap_d    = rw_cap_q;
    wreg_cap_d  = wreg_cap_q;
    wb_valid_d  = 1'b0;
    reg_write_d = 1'b0;
    write_reg_d = write_reg_q;
    result_d    = result_q;
    timeout_d   = 1'b0;
    align_err_d = 1'b0;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_ValidW) begin
          if (!is_load) begin
            wb_valid_d  = 1'b1;
            reg_write_d = i_RegWriteW;
            write_reg_d = i_WriteRegW;
            case (i_MemtoRegW)
              2'b00:   result_d = i_ALUOutW;
              2'b10:   result_d = pc_ext;
              default: result_d = '0;
            endcase
          end else if (i_MemRspValid) begin
            wb_valid_d  = 1'b1;
            reg_write_d = i_RegWriteW & ~mis_live;
            write_reg_d = i_WriteRegW;
            result_d    = extract_load(i_MemRspData, off_live, i_MemDataSelW);
            align_err_d = mis_live;
          end else begin
            stall      = 1'b1;
            off_cap_d  = off_live;
            sel_cap_d  = i_MemDataSelW;
            rw_cap_d   = i_RegWriteW;
            wreg_cap_d = i_WriteRegW;
            cnt_d      = '0;
            state_d    = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (i_MemRspValid) begin
          wb_valid_d  = 1'b1;
          reg_write_d = rw_cap_q & ~mis_cap;
          write_reg_d = wreg_cap_q;
          result_d    = extract_load(i_MemRspData, off_cap_q, sel_cap_q);
          align_err_d = mis_cap;
          state_d     = S_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          wb_valid_d  = 1'b1;
          reg_write_d = 1'b0;
          write_reg_d = wreg_cap_q;
          result_d    = '0;
          timeout_d   = 1'b1;
          align_err_d = mis_cap;
          state_d     = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Reset masks the stall so that upstream is never frozen while the stage
  // is being cleared.
  assign o_StallW = stall & ~i_rst;

  // All state lives in this block. Reset drops any pending load and commits
  // nothing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_cap_q   <= '0;
      sel_cap_q   <= '0;
      rw_cap_q    <= 1'b0;
      wreg_cap_q  <= '0;
      wb_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_cap_q   <= off_cap_d;
      sel_cap_q   <= sel_cap_d;
      rw_cap_q    <= rw_cap_d;
      wreg_cap_q  <= wreg_cap_d;
      wb_valid_q  <= wb_valid_d;
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      result_q    <= result_d;
      timeout_q   <= timeout_d;
      align_err_q <= align_err_d;
    end
  end

  assign o_WbValidW    = wb_valid_q;
  assign o_RegWriteW   = reg_write_q;
  assign o_WriteRegW   = write_reg_q;
  assign o_ResultW     = result_q;
  assign o_MemTimeoutW = timeout_q;
  assign o_AlignErrW   = align_err_q;

endmodule

// File: tb/tb_wb_load_commit_unit.sv
// Testbench for wb_load_commit_unit (32-bit datapath, TIMEOUT_CYCLES=4).
// Directed stimulus pushes the expected commits into a queue. A monitor
// running on the falling edge pops and compares each commit as it appears.
// Combinational stall values are checked directly after each input change.

module tb_wb_load_commit_unit;

  logic        clk;
  logic        rst;
  logic        validW;
  logic [31:0] aluOutW;
  logic [31:0] pcPlus4W;
  logic [1:0]  memtoRegW;
  logic [2:0]  memDataSelW;
  logic        regWriteW;
  logic [4:0]  writeRegW;
  logic        memRspValid;
  logic [31:0] memRspData;
  logic        stallW;
  logic        wbValidW;
  logic        regWriteOut;
  logic [4:0]  writeRegOut;
  logic [31:0] resultW;
  logic        memTimeoutW;
  logic        alignErrW;

  int checkCount;
  int errorCount;

  typedef struct {
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] result;
    logic        timeout;
    logic        alignErr;
  } commitExp_t;

  commitExp_t expQ[$];

  wb_load_commit_unit #(
    .DATA_WIDTH(32),
    .ADDRESS_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_ValidW(validW),
    .i_ALUOutW(aluOutW),
    .i_PCPlus4W(pcPlus4W),
    .i_MemtoRegW(memtoRegW),
    .i_MemDataSelW(memDataSelW),
    .i_RegWriteW(regWriteW),
    .i_WriteRegW(writeRegW),
    .i_MemRspValid(memRspValid),
    .i_MemRspData(memRspData),
    .o_StallW(stallW),
    .o_WbValidW(wbValidW),
    .o_RegWriteW(regWriteOut),
    .o_WriteRegW(writeRegOut),
    .o_ResultW(resultW),
    .o_MemTimeoutW(memTimeoutW),
    .o_AlignErrW(alignErrW)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one W-stage instruction plus the memory response for this cycle.
  task automatic applyStimulus(input logic v, input logic [1:0] m2r,
                               input logic [31:0] alu, input logic [31:0] pc4,
                               input logic [2:0] sel, input logic rw,
                               input logic [4:0] wreg, input logic rspV,
                               input logic [31:0] rspD);
    validW      = v;
    memtoRegW   = m2r;
    aluOutW     = alu;
    pcPlus4W    = pc4;
    memDataSelW = sel;
    regWriteW   = rw;
    writeRegW   = wreg;
    memRspValid = rspV;
    memRspData  = rspD;
  endtask

  task automatic pushExp(input logic rw, input logic [4:0] wreg,
                         input logic [31:0] res, input logic tmo,
                         input logic aerr);
    commitExp_t e;
    e.regWrite = rw;
    e.writeReg = wreg;
    e.result   = res;
    e.timeout  = tmo;
    e.alignErr = aerr;
    expQ.push_back(e);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the combinational stall once the inputs have settled.
  task automatic checkStall(input string name, input logic expected);
    #1;
    checkOutput(name, {31'd0, stallW}, {31'd0, expected});
  endtask

  // Monitor: every commit must match the oldest queued expectation. Outside
  // a commit, the strobes must stay low.
  always @(negedge clk) begin
    if (wbValidW) begin
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpected_commit: got wreg=%0d result=0x%08h expected no commit",
                 writeRegOut, resultW);
      end else begin
        commitExp_t e;
        e = expQ.pop_front();
        checkOutput("commit_regwrite", {31'd0, regWriteOut}, {31'd0, e.regWrite});
        checkOutput("commit_writereg", {27'd0, writeRegOut}, {27'd0, e.writeReg});
        checkOutput("commit_result", resultW, e.result);
        checkOutput("commit_timeout", {31'd0, memTimeoutW}, {31'd0, e.timeout});
        checkOutput("commit_alignerr", {31'd0, alignErrW}, {31'd0, e.alignErr});
      end
    end else begin
      checkOutput("idle_strobes", {29'd0, regWriteOut, memTimeoutW, alignErrW}, 32'd0);
    end
  end

  initial begin
    checkCount = 0;
    errorCount = 0;

    // Reset with a stalling load present: the stall must stay masked.
    rst = 1'b1;
    applyStimulus(1, 2'b01, 32'h0, 32'h0, 3'b000, 1, 5'd1, 0, 32'h0);
    repeat (3) tick();
    checkStall("reset_stall", 1'b0);
    checkOutput("reset_wbvalid", {31'd0, wbValidW}, 32'd0);
    checkOutput("reset_result", resultW, 32'd0);
    checkOutput("reset_writereg", {27'd0, writeRegOut}, 32'd0);
    rst = 1'b0;
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 3'b000, 0, 5'd0, 0, 32'h0);
    tick();

    // ALU, PC+4 and zero-source commits back to back.
    applyStimulus(1, 2'b00, 32'h1234_5678, 32'h0, 3'b000, 1, 5'd7, 0, 32'h0);
    pushExp(1, 5'd7, 32'h1234_5678, 0, 0);
    checkStall("alu_stall", 1'b0);
    tick();
    applyStimulus(1, 2'b10, 32'hDEAD_BEEF, 32'h0000_0400, 3'b000, 1, 5'd31, 0, 32'h0);
    pushExp(1, 5'd31, 32'h0000_0400, 0, 0);
    tick();
    applyStimulus(1, 2'b11, 32'hDEAD_BEEF, 32'h0000_0400, 3'b000, 0, 5'd3, 0, 32'h0);
    pushExp(0, 5'd3, 32'h0, 0, 0);
    tick();

    // Signed byte load at offset 2, response three cycles late.
    applyStimulus(1, 2'b01, 32'h0000_1002, 32'h0, 3'b011, 1, 5'd9, 0, 32'h0);
    checkStall("byte_stall0", 1'b1);
    tick();
    checkStall("byte_stall1", 1'b1);
    tick();
    checkStall("byte_stall2", 1'b1);
    tick();
    memRspValid = 1'b1;
    memRspData  = 32'hAABB_CCDD;
    pushExp(1, 5'd9, 32'hFFFF_FFBB, 0, 0);
    checkStall("byte_rsp_stall", 1'b0);
    tick();

    // Half loads with a same-cycle response, unsigned then signed.
    applyStimulus(1, 2'b01, 32'h0000_2002, 32'h0, 3'b010, 1, 5'd4, 1, 32'h8001_0000);
    pushExp(1, 5'd4, 32'h0000_8001, 0, 0);
    checkStall("halfu_stall", 1'b0);
    tick();
    applyStimulus(1, 2'b01, 32'h0000_2002, 32'h0, 3'b001, 1, 5'd5, 1, 32'h8001_0000);
    pushExp(1, 5'd5, 32'hFFFF_8001, 0, 0);
    tick();
    // Full-width and unsigned byte loads.
    applyStimulus(1, 2'b01, 32'h0000_3000, 32'h0, 3'b000, 1, 5'd6, 1, 32'hCAFE_F00D);
    pushExp(1, 5'd6, 32'hCAFE_F00D, 0, 0);
    tick();
    applyStimulus(1, 2'b01, 32'h0000_3003, 32'h0, 3'b100, 1, 5'd8, 1, 32'h9A00_0000);
    pushExp(1, 5'd8, 32'h0000_009A, 0, 0);
    tick();

    // Timeout: four stall cycles, then an abandoned commit.
    applyStimulus(1, 2'b01, 32'h0000_5000, 32'h0, 3'b000, 1, 5'd10, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkStall("timeout_stall", 1'b1);
      tick();
    end
    pushExp(0, 5'd10, 32'h0, 1, 0);
    checkStall("timeout_release", 1'b0);
    tick();

    // A response in the last watchdog cycle beats the timeout.
    applyStimulus(1, 2'b01, 32'h0000_5000, 32'h0, 3'b000, 1, 5'd11, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkStall("late_rsp_stall", 1'b1);
      tick();
    end
    memRspValid = 1'b1;
    memRspData  = 32'h1122_3344;
    pushExp(1, 5'd11, 32'h1122_3344, 0, 0);
    checkStall("late_rsp_release", 1'b0);
    tick();

    // Reset while waiting drops the load; a stray response afterwards is
    // ignored.
    applyStimulus(1, 2'b01, 32'h0000_6000, 32'h0, 3'b000, 1, 5'd12, 0, 32'h0);
    tick();
    checkStall("rst_wait_stall", 1'b1);
    rst = 1'b1;
    checkStall("rst_wait_masked", 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 2'b01, 32'h0, 32'h0, 3'b000, 1, 5'd12, 1, 32'h5555_5555);
    checkStall("stray_rsp_stall", 1'b0);
    repeat (2) tick();

    // Misaligned signed half at offset 1.
    applyStimulus(1, 2'b01, 32'h0000_4001, 32'h0, 3'b001, 1, 5'd13, 1, 32'h1234_5678);
`ifdef WB_ALIGN_CHECK_EN
    pushExp(0, 5'd13, 32'h0000_3456, 0, 1);
`else
    pushExp(1, 5'd13, 32'h0000_3456, 0, 0);
`endif
    tick();

    applyStimulus(0, 2'b00, 32'h0, 32'h0, 3'b000, 0, 5'd0, 0, 32'h0);
    repeat (3) tick();
    checkOutput("pending_commits", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
